// File: rtl/kamikaze_pkg.sv
// kamikaze_pkg: write-back widths, register constants and the request type
package kamikaze_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // One-hot scoreboard bit for a register; x0 never maps to a bit
    function automatic logic [NREG-1:0] reg_mask(input logic [REG_AW-1:0] r);
        return (NREG'(1) << r) & ~NREG'(1);
    endfunction
endpackage

// File: rtl/kamikaze_wb_ctrl_if.sv
// kamikaze_wb_ctrl_if: issue, write-back request and register-file port bundle
interface kamikaze_wb_ctrl_if;
    import kamikaze_pkg::*;
    logic              iss_valid_i;
    logic [REG_AW-1:0] iss_rd_i;
    logic              iss_rd_we_i;
    logic [REG_AW-1:0] iss_rs1_i;
    logic [REG_AW-1:0] iss_rs2_i;
    logic              hazard_o;
    logic              req0_valid_i;
    logic [REG_AW-1:0] req0_rd_i;
    logic [XLEN-1:0]   req0_data_i;
    logic              req0_ready_o;
    logic              req1_valid_i;
    logic [REG_AW-1:0] req1_rd_i;
    logic [XLEN-1:0]   req1_data_i;
    logic              req1_ready_o;
    logic [REG_AW-1:0] rf_waddr_o;
    logic [XLEN-1:0]   rf_wdata_o;
    logic              rf_we_o;
    logic [NREG-1:0]   busy_o;

    modport master (
        output iss_valid_i, iss_rd_i, iss_rd_we_i, iss_rs1_i, iss_rs2_i,
        output req0_valid_i, req0_rd_i, req0_data_i,
        output req1_valid_i, req1_rd_i, req1_data_i,
        input  hazard_o, req0_ready_o, req1_ready_o,
        input  rf_waddr_o, rf_wdata_o, rf_we_o, busy_o
    );

    modport slave (
        input  iss_valid_i, iss_rd_i, iss_rd_we_i, iss_rs1_i, iss_rs2_i,
        input  req0_valid_i, req0_rd_i, req0_data_i,
        input  req1_valid_i, req1_rd_i, req1_data_i,
        output hazard_o, req0_ready_o, req1_ready_o,
        output rf_waddr_o, rf_wdata_o, rf_we_o, busy_o
    );
endinterface

// File: rtl/kamikaze_rr_arb2.sv
// kamikaze_rr_arb2: two-way round-robin arbiter; the loser has priority next cycle
module kamikaze_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic rr_ptr_q;
    logic rr_ptr_d;
    logic g0;
    logic g1;

    assign g0 = req_i[0] & (~req_i[1] | ~rr_ptr_q);
    assign g1 = req_i[1] & (~req_i[0] | rr_ptr_q);
    assign gnt_o = {g1, g0};
    assign rr_ptr_d = (g0 | g1) ? g0 : rr_ptr_q;

    always_ff @(posedge clk_i) begin
        rr_ptr_q <= rst_i ? 1'b0 : rr_ptr_d;
    end
endmodule

// File: rtl/kamikaze_wb_ctrl.sv
// kamikaze_wb_ctrl: shares the register-file write port and tracks pending destinations
module kamikaze_wb_ctrl
    import kamikaze_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    kamikaze_wb_ctrl_if.slave  bus
);
    wb_req_t         req0;
    wb_req_t         req1;
    wb_req_t         win;
    logic [1:0]      gnt;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] clr;
    logic [NREG-1:0] set;
    logic            hazard;

    assign req0 = '{valid: bus.req0_valid_i, rd: bus.req0_rd_i, data: bus.req0_data_i};
    assign req1 = '{valid: bus.req1_valid_i, rd: bus.req1_rd_i, data: bus.req1_data_i};

    kamikaze_rr_arb2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i ({req1.valid, req0.valid}),
        .gnt_o (gnt)
    );

    // No bypass: a register written this cycle still stalls until the next one
    always_comb begin
        win    = gnt[1] ? req1 : gnt[0] ? req0 : '0;
        hazard = busy_q[bus.iss_rs1_i] | busy_q[bus.iss_rs2_i] | (bus.iss_rd_we_i & busy_q[bus.iss_rd_i]);
        clr    = win.valid ? reg_mask(win.rd) : '0;
        set    = (bus.iss_valid_i & ~hazard & bus.iss_rd_we_i) ? reg_mask(bus.iss_rd_i) : '0;
        busy_d = (busy_q & ~clr) | set;
    end

    always_ff @(posedge clk_i) begin
        busy_q <= rst_i ? '0 : busy_d;
    end

    assign bus.hazard_o     = hazard;
    assign bus.req0_ready_o = gnt[0];
    assign bus.req1_ready_o = gnt[1];
    assign bus.rf_waddr_o   = win.rd;
    assign bus.rf_wdata_o   = win.data;
    assign bus.rf_we_o      = win.valid & (win.rd != REG_ZERO);
    assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_kamikaze_wb_ctrl.sv
// tb_kamikaze_wb_ctrl: directed and random checks against a behavioural scoreboard model
module tb_kamikaze_wb_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   errors = 0;
    int   checks = 0;

    kamikaze_wb_ctrl_if bus ();
    kamikaze_wb_ctrl dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    bit mbusy[32];
    int mrr = 0;
    bit acc0 = 0;
    bit acc1 = 0;
    bit mlive = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_winner();
        if (bus.req0_valid_i && bus.req1_valid_i) return mrr;
        if (bus.req0_valid_i) return 0;
        if (bus.req1_valid_i) return 1;
        return -1;
    endfunction

    function automatic bit m_hazard();
        return mbusy[bus.iss_rs1_i] || mbusy[bus.iss_rs2_i] || (bus.iss_rd_we_i && mbusy[bus.iss_rd_i]);
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = mbusy[i];
        return b;
    endfunction

    // Model state advances with the clock edge, from the inputs applied in that cycle
    task automatic model_step();
        int w;
        bit h;
        w = m_winner();
        h = m_hazard();
        acc0 = (w == 0);
        acc1 = (w == 1);
        if (rst_i) begin
            foreach (mbusy[i]) mbusy[i] = 0;
            mrr = 0;
        end else begin
            if (w == 0) mbusy[bus.req0_rd_i] = 0;
            if (w == 1) mbusy[bus.req1_rd_i] = 0;
            if (w >= 0) mrr = 1 - w;
            if (bus.iss_valid_i && !h && bus.iss_rd_we_i && bus.iss_rd_i != 0) mbusy[bus.iss_rd_i] = 1;
        end
        mlive = 1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    always @(negedge clk_i) begin : compare
        int w;
        logic [4:0] ea;
        logic [31:0] ed;
        if (mlive) begin
            w  = m_winner();
            ea = (w == 0) ? bus.req0_rd_i : (w == 1) ? bus.req1_rd_i : 5'd0;
            ed = (w == 0) ? bus.req0_data_i : (w == 1) ? bus.req1_data_i : 32'd0;
            chk("ready0", 32'(bus.req0_ready_o), 32'(w == 0));
            chk("ready1", 32'(bus.req1_ready_o), 32'(w == 1));
            chk("rf_waddr", 32'(bus.rf_waddr_o), 32'(ea));
            chk("rf_wdata", bus.rf_wdata_o, ed);
            chk("rf_we", 32'(bus.rf_we_o), 32'(w >= 0 && ea != 0));
            chk("hazard", 32'(bus.hazard_o), 32'(m_hazard()));
            chk("busy", bus.busy_o, m_busy());
        end
    end

    task automatic idle();
        bus.iss_valid_i = 0; bus.iss_rd_i = 0; bus.iss_rd_we_i = 0;
        bus.iss_rs1_i = 0; bus.iss_rs2_i = 0;
        bus.req0_valid_i = 0; bus.req0_rd_i = 0; bus.req0_data_i = 0;
        bus.req1_valid_i = 0; bus.req1_rd_i = 0; bus.req1_data_i = 0;
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.iss_valid_i = 1; bus.iss_rd_i = rd; bus.iss_rd_we_i = 1;
    endtask

    initial begin
        idle();
        rst_i = 1;
        repeat (2) tick();
        rst_i = 0;
        #2;
        chk("rst_busy", bus.busy_o, 32'd0);
        chk("rst_hazard", 32'(bus.hazard_o), 32'd0);
        chk("rst_we", 32'(bus.rf_we_o), 32'd0);
        chk("rst_ready", 32'({bus.req0_ready_o, bus.req1_ready_o}), 32'd0);
        tick();

        issue(5'd5);
        #2 chk("iss5_hazard", 32'(bus.hazard_o), 32'd0);
        tick();
        idle();
        bus.req0_valid_i = 1; bus.req0_rd_i = 5; bus.req0_data_i = 32'hDEADBEEF;
        #2;
        chk("alu_busy5_set", 32'(bus.busy_o[5]), 32'd1);
        chk("alu_ready0", 32'(bus.req0_ready_o), 32'd1);
        chk("alu_we", 32'(bus.rf_we_o), 32'd1);
        chk("alu_waddr", 32'(bus.rf_waddr_o), 32'd5);
        chk("alu_wdata", bus.rf_wdata_o, 32'hDEADBEEF);
        tick();
        idle();
        #2 chk("alu_busy5_clr", 32'(bus.busy_o[5]), 32'd0);

        rst_i = 1;
        tick();
        rst_i = 0;
        bus.req0_valid_i = 1; bus.req0_rd_i = 10; bus.req0_data_i = 32'hA0;
        bus.req1_valid_i = 1; bus.req1_rd_i = 20; bus.req1_data_i = 32'hB0;
        for (int k = 0; k < 4; k++) begin
            #2 chk("contention_grant0", 32'(bus.req0_ready_o), 32'(k % 2 == 0));
            tick();
            if (acc0) begin bus.req0_rd_i++; bus.req0_data_i++; end
            if (acc1) begin bus.req1_rd_i++; bus.req1_data_i++; end
        end
        idle();

        issue(5'd7);
        tick();
        idle();
        bus.iss_rs1_i = 7;
        #2 chk("haz_busy7", 32'(bus.hazard_o), 32'd1);
        tick();
        bus.req0_valid_i = 1; bus.req0_rd_i = 7; bus.req0_data_i = 32'h77;
        #2;
        chk("haz_during_write", 32'(bus.hazard_o), 32'd1);
        chk("haz_write_we", 32'(bus.rf_we_o), 32'd1);
        tick();
        bus.req0_valid_i = 0;
        #2 chk("haz_released", 32'(bus.hazard_o), 32'd0);
        idle();

        bus.req1_valid_i = 1; bus.req1_rd_i = 9; bus.req1_data_i = 32'h99;
        issue(5'd9);
        #2 chk("coll_ready1", 32'(bus.req1_ready_o), 32'd1);
        tick();
        idle();
        #2 chk("coll_busy9", 32'(bus.busy_o[9]), 32'd1);

        bus.req1_valid_i = 1; bus.req1_rd_i = 0; bus.req1_data_i = 32'h1234;
        issue(5'd0);
        #2;
        chk("x0_ready1", 32'(bus.req1_ready_o), 32'd1);
        chk("x0_we", 32'(bus.rf_we_o), 32'd0);
        chk("x0_hazard", 32'(bus.hazard_o), 32'd0);
        tick();
        idle();
        #2 chk("x0_busy", bus.busy_o, 32'h0000_0200);

        rst_i = 1;
        tick();
        rst_i = 0;
        for (int n = 0; n < 3000; n++) begin
            if (acc0 || !bus.req0_valid_i) begin
                bus.req0_valid_i = ($urandom_range(2) != 0);
                bus.req0_rd_i = 5'($urandom_range(7));
                bus.req0_data_i = $urandom;
            end
            if (acc1 || !bus.req1_valid_i) begin
                bus.req1_valid_i = ($urandom_range(2) != 0);
                bus.req1_rd_i = 5'($urandom_range(7));
                bus.req1_data_i = $urandom;
            end
            bus.iss_valid_i = $urandom_range(1) != 0;
            bus.iss_rd_we_i = $urandom_range(3) != 0;
            bus.iss_rd_i = 5'($urandom_range(7));
            bus.iss_rs1_i = 5'($urandom_range(7));
            bus.iss_rs2_i = 5'($urandom_range(7));
            tick();
        end
        idle();
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/kamikaze_wb_ctrl.md
Name: kamikaze_wb_ctrl

Overview:
- Write-back controller and scoreboard for the 2R/1W integer register file.
- Shares the register file's single write port between two producers:
  - requester 0: ALU/CSR path
  - requester 1: load/store unit
- Arbitration is round-robin.
- Tracks pending destination registers in a 32-bit busy scoreboard and raises a hazard stall towards the issue stage.
- Sits between execute/LSU outputs and the register file write port (waddr/wdata/we).

Parameters:
- XLEN, 32, data width of write-back values.
- NREG, 32, number of architectural registers (log2 = 5 address bits).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; synchronous, active-high
- iss_valid_i  in  1  instruction issuing this cycle (when hazard_o=0)
- iss_rd_i  in  5  destination of issuing instruction
- iss_rd_we_i  in  1  issuing instruction writes iss_rd_i
- iss_rs1_i  in  5  source 1 of candidate instruction
- iss_rs2_i  in  5  source 2 of candidate instruction
- hazard_o  out  1  stall: a source or the destination of the candidate is pending
- req0_valid_i  in  1  ALU write-back request
- req0_rd_i  in  5  ALU destination
- req0_data_i  in  XLEN  ALU result
- req0_ready_o  out  1  ALU request granted this cycle
- req1_valid_i, req1_rd_i, req1_data_i, req1_ready_o  as req0, for the LSU
- rf_waddr_o  out  5  to register file write address
- rf_wdata_o  out  XLEN  to register file write data
- rf_we_o  out  1  to register file write enable
- busy_o  out  NREG  scoreboard snapshot (debug/verification)

Behaviour:
- State:
  - busy[NREG-1:0] register
  - rr_ptr register, 1 bit: the requester that gets priority next
- Reset (rst_i=1 at posedge):
  - busy=0, rr_ptr=0.
  - Outputs during/after reset are combinational from the cleared state:
    - hazard_o=0 unless inputs force otherwise; with busy=0 this means hazard_o=0.
    - rf_we_o follows requests.
  - A write granted in the reset cycle still reaches the register file; the bench holds requests low during reset.
- Arbitration (combinational, same cycle):
  - If only one requester is valid, it is granted.
  - If both are valid, the one equal to rr_ptr is granted.
  - Exactly one of req0_ready_o and req1_ready_o is high when any request is valid; neither is high otherwise.
  - Ready never depends on the requester's own data. Handshake is valid&ready; a requester holds valid/rd/data stable until ready.
- rr_ptr update (posedge):
  - On a grant, rr_ptr <= ~granted index.
  - Otherwise rr_ptr holds.
  - Guarantees no starvation: the losing requester wins the next cycle.
- Write port:
  - rf_waddr_o/rf_wdata_o = granted requester's rd/data, else 0.
  - rf_we_o = grant & (rd != 0).
  - The register file captures the write at the next posedge, giving 1-cycle write latency.
  - A request with rd=0 is accepted (ready=1) but never drives we.
- Scoreboard update (posedge), applied in this order:
  - Clear: on grant, busy[granted rd] <= 0.
  - Set: if iss_valid_i & ~hazard_o & iss_rd_we_i & iss_rd_i!=0, then busy[iss_rd_i] <= 1.
  - Same register cleared and set in the same cycle: set wins, so busy stays 1.
  - busy[0] is constant 0.
- Hazard (combinational from registered busy only; no bypass):
  - hazard_o = busy[rs1] | busy[rs2] | (iss_rd_we_i & busy[iss_rd_i]), with busy[0]=0.
  - A register being written this cycle still reports busy; the stall releases the cycle after the write.
  - The rd term prevents write-after-write reordering between ALU and LSU.
- Issue handling: iss_valid_i while hazard_o=1 is ignored; no set occurs.

Decomposition:
- Package kamikaze_pkg:
  - XLEN
  - REG_AW = 5
  - REG_ZERO = 5'd0
  - wb_req_t typedef: valid, rd, data
- One natural sub-module, kamikaze_rr_arb2: a 2-input round-robin arbiter holding rr_ptr, with grant outputs.
- Scoreboard and write-port muxing stay in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: rst_i high 2 cycles, then low.
  - Required: busy_o=0, hazard_o=0, rf_we_o=0, both readies 0.
- Single ALU write:
  - Stimulus: issue rd=5 (busy_o[5]=1 next cycle); req0 valid rd=5 data=32'hDEADBEEF.
  - Required: req0_ready_o=1, rf_we_o=1, rf_waddr_o=5, rf_wdata_o=DEADBEEF; busy_o[5]=0 after the edge.
- Contention:
  - Stimulus: req0 and req1 valid for 4 cycles, each re-presenting a new request after acceptance.
  - Required: grants alternate 0,1,0,1 starting from rr_ptr=0 after reset.
- Hazard:
  - Stimulus: busy[7]=1, candidate rs1=7.
  - Required: hazard_o=1. Grant a write to rd=7 and hazard_o stays 1 in that cycle, then falls to 0 the next cycle.
- Set/clear collision:
  - Stimulus: grant a write to rd=9 and issue a new rd=9 in the same cycle.
  - Required: busy_o[9] remains 1.
- x0 handling:
  - Stimulus: req1 rd=0 data=32'h1234.
  - Required: req1_ready_o=1, rf_we_o=0. Issuing rd=0 never sets busy, and rs1=0 never causes a hazard.
